// File: rtl/board_cell_fetch_pkg.sv
// Shared constants and types for the board cell fetch stage: grid geometry,
// entity codes, FSM state encoding and the cell address helper.
package board_cell_fetch_pkg;

  localparam int H_SQUARE = 20;
  localparam int V_SQUARE = 20;
  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = 10;
  localparam int ENT_W  = 2;

  typedef logic [ENT_W-1:0] ent_t;

  localparam ent_t ENT_APPLE   = 2'd0;
  localparam ent_t ENT_HEAD    = 2'd1;
  localparam ent_t ENT_TAIL    = 2'd2;
  localparam ent_t ENT_NOTHING = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fetch_state_e;

  // Row-major cell index; callers guarantee row/col are inside the grid.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [4:0] col);
    return ADDR_W'(int'(row) * GRID_W + int'(col));
  endfunction

endpackage

// File: rtl/board_cell_fetch_ram.sv
// Board storage: one write port, one registered read port, no reset.
// A read and a write to the same address on the same edge return the
// value held before the write.
module board_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 768
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read in one block so the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/board_cell_fetch.sv
// Maps the VGA scan coordinate to a grid cell, looks up the entity code in
// the board RAM and presents it two cycles later alongside the matching
// delayed coordinate. Also arbitrates game-logic writes against a
// full-board clear sweep.
//
// Write handshake: iWr_en is a single-cycle request with no back-pressure.
// A request is accepted only in IDLE with an in-range cell; an accepted
// request is reported by oWr_ack on the following cycle. A request that
// is not accepted produces no ack and must be reissued by the requester.
module board_cell_fetch
  import board_cell_fetch_pkg::*;
(
  input  logic       iVGA_CLK,
  input  logic       reset_n,
  input  logic [9:0] iVGA_X,
  input  logic [9:0] iVGA_Y,
  input  logic       iWr_en,
  input  logic [4:0] iWr_col,
  input  logic [4:0] iWr_row,
  input  logic [1:0] iWr_ent,
  input  logic       iClear,
  output logic [1:0] oEnt,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oWr_ack,
  output logic       oClear_busy
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] clrAddr;

  logic [9:0]        xS1;
  logic [9:0]        yS1;
  logic [4:0]        colS1;
  logic [4:0]        rowS1;
  logic              inGridS1;
  logic              inGridS2;

  logic [ADDR_W-1:0] rdAddr;
  ent_t              ramRdata;

  logic              ramWe;
  logic [ADDR_W-1:0] ramWaddr;
  ent_t              ramWdata;
  logic              wrInRange;
  logic              wrCommit;

  // Stage 1 and 2 of the coordinate pipeline plus the matching X/Y delay line.
  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      xS1      <= '0;
      yS1      <= '0;
      colS1    <= '0;
      rowS1    <= '0;
      inGridS1 <= 1'b0;
      oVGA_X   <= '0;
      oVGA_Y   <= '0;
      inGridS2 <= 1'b0;
    end else begin
      xS1      <= iVGA_X;
      yS1      <= iVGA_Y;
      colS1    <= 5'(iVGA_X / 10'(H_SQUARE));
      rowS1    <= 5'(iVGA_Y / 10'(V_SQUARE));
      inGridS1 <= (iVGA_X < 10'(H_ACTIVE)) && (iVGA_Y < 10'(V_ACTIVE));
      oVGA_X   <= xS1;
      oVGA_Y   <= yS1;
      inGridS2 <= inGridS1;
    end
  end

  // Off-screen coordinates truncate to arbitrary cells; park the read at 0
  // so the RAM is never indexed past its last entry.
  assign rdAddr = inGridS1 ? cell_addr(rowS1, colS1) : '0;

  // The clear sweep owns the write port; game writes only land in IDLE.
  always_comb begin
    ramWe     = 1'b0;
    ramWaddr  = '0;
    ramWdata  = ENT_NOTHING;
    wrCommit  = 1'b0;
    wrInRange = ({1'b0, iWr_col} < 6'(GRID_W)) && ({1'b0, iWr_row} < 6'(GRID_H));
    if (state == ST_CLEAR) begin
      ramWe    = 1'b1;
      ramWaddr = clrAddr;
      ramWdata = ENT_NOTHING;
    end else if (iWr_en && wrInRange) begin
      ramWe    = 1'b1;
      ramWaddr = cell_addr(iWr_row, iWr_col);
      ramWdata = iWr_ent;
      wrCommit = 1'b1;
    end
  end

  // Clear FSM with registered busy flag and write acknowledge.
  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_CLEAR;
      clrAddr     <= '0;
      oClear_busy <= 1'b1;
      oWr_ack     <= 1'b0;
    end else begin
      oWr_ack <= wrCommit;
      case (state)
        ST_IDLE: begin
          if (iClear) begin
            state       <= ST_CLEAR;
            clrAddr     <= '0;
            oClear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clrAddr == LAST_ADDR) begin
            state       <= ST_IDLE;
            oClear_busy <= 1'b0;
          end else begin
            clrAddr <= clrAddr + 10'd1;
          end
        end
        default: begin
          state       <= ST_CLEAR;
          clrAddr     <= '0;
          oClear_busy <= 1'b1;
        end
      endcase
    end
  end

  // While clearing, the board contents are stale, so show empty cells.
  assign oEnt = (inGridS2 && state == ST_IDLE) ? ramRdata : ENT_NOTHING;

  board_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENT_W),
    .DEPTH  (CELLS)
  ) uRam (
    .clk    (iVGA_CLK),
    .wrEn   (ramWe),
    .wrAddr (ramWaddr),
    .wrData (ramWdata),
    .rdAddr (rdAddr),
    .rdData (ramRdata)
  );

endmodule

// File: tb/tb_board_cell_fetch.sv
// Directed bench for board_cell_fetch: one task per scenario, inline checks.
module tb_board_cell_fetch;

  logic       iVGA_CLK;
  logic       reset_n;
  logic [9:0] iVGA_X;
  logic [9:0] iVGA_Y;
  logic       iWr_en;
  logic [4:0] iWr_col;
  logic [4:0] iWr_row;
  logic [1:0] iWr_ent;
  logic       iClear;
  logic [1:0] oEnt;
  logic [9:0] oVGA_X;
  logic [9:0] oVGA_Y;
  logic       oWr_ack;
  logic       oClear_busy;

  int errors = 0;
  int checks = 0;

  board_cell_fetch dut (
    .iVGA_CLK    (iVGA_CLK),
    .reset_n     (reset_n),
    .iVGA_X      (iVGA_X),
    .iVGA_Y      (iVGA_Y),
    .iWr_en      (iWr_en),
    .iWr_col     (iWr_col),
    .iWr_row     (iWr_row),
    .iWr_ent     (iWr_ent),
    .iClear      (iClear),
    .oEnt        (oEnt),
    .oVGA_X      (oVGA_X),
    .oVGA_Y      (oVGA_Y),
    .oWr_ack     (oWr_ack),
    .oClear_busy (oClear_busy)
  );

  // Clock and global time limit
  initial begin
    iVGA_CLK = 1'b0;
    forever #5 iVGA_CLK = ~iVGA_CLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // Driver helpers: all inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic do_write(input int col, input int row, input logic [1:0] ent,
                          output logic ack);
    iWr_en  = 1'b1;
    iWr_col = 5'(col);
    iWr_row = 5'(row);
    iWr_ent = ent;
    tick(1);
    ack    = oWr_ack;
    iWr_en = 1'b0;
  endtask

  task automatic read_cell(input int x, input int y, output logic [1:0] ent,
                           output logic [9:0] ox, output logic [9:0] oy);
    iVGA_X = 10'(x);
    iVGA_Y = 10'(y);
    tick(2);
    ent = oEnt;
    ox  = oVGA_X;
    oy  = oVGA_Y;
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    logic [1:0] ent;
    logic [9:0] ox, oy;
    reset_n = 1'b0;
    tick(2);
    checks++; if (oEnt !== 2'd3) begin errors++; $display("FAIL reset_ent: got %0d expected 3", oEnt); end
    checks++; if (oVGA_X !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", oVGA_X); end
    checks++; if (oVGA_Y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", oVGA_Y); end
    checks++; if (oWr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", oWr_ack); end
    checks++; if (oClear_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", oClear_busy); end
    reset_n = 1'b1;
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (oClear_busy === 1'b1 && cnt < 2000);
    checks++; if (cnt != 768) begin errors++; $display("FAIL init_sweep_len: got %0d cycles expected 768", cnt); end
    bad = 0;
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 32; c++) begin
        read_cell(c * 20 + 7, r * 20 + 11, ent, ox, oy);
        if (ent !== 2'd3) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_board_empty: got %0d non-empty cells expected 0", bad); end
  endtask

  task automatic test_write_read();
    logic ack;
    do_write(3, 2, 2'd1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %0b expected 1", ack); end
    tick(1);
    checks++; if (oWr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %0b expected 0", oWr_ack); end
    // Change the coordinate after one cycle to pin the latency at exactly 2.
    iVGA_X = 10'd65;
    iVGA_Y = 10'd45;
    tick(1);
    iVGA_X = 10'd0;
    iVGA_Y = 10'd0;
    tick(1);
    checks++; if (oEnt !== 2'd1) begin errors++; $display("FAIL lat_ent: got %0d expected 1", oEnt); end
    checks++; if (oVGA_X !== 10'd65) begin errors++; $display("FAIL lat_x: got %0d expected 65", oVGA_X); end
    checks++; if (oVGA_Y !== 10'd45) begin errors++; $display("FAIL lat_y: got %0d expected 45", oVGA_Y); end
    tick(1);
    checks++; if (oEnt !== 2'd3) begin errors++; $display("FAIL lat_next_ent: got %0d expected 3", oEnt); end
    checks++; if (oVGA_X !== 10'd0) begin errors++; $display("FAIL lat_next_x: got %0d expected 0", oVGA_X); end
  endtask

  task automatic test_out_of_grid();
    logic ack;
    logic [1:0] ent;
    logic [9:0] ox, oy;
    do_write(31, 23, 2'd2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL edge_wr_ack: got %0b expected 1", ack); end
    read_cell(639, 479, ent, ox, oy);
    checks++; if (ent !== 2'd2) begin errors++; $display("FAIL edge_cell: got %0d expected 2", ent); end
    read_cell(640, 479, ent, ox, oy);
    checks++; if (ent !== 2'd3) begin errors++; $display("FAIL x640: got %0d expected 3", ent); end
    // X=700 truncates onto column 3 of row 2, which holds HEAD; must still be empty.
    read_cell(700, 45, ent, ox, oy);
    checks++; if (ent !== 2'd3) begin errors++; $display("FAIL x700: got %0d expected 3", ent); end
    checks++; if (ox !== 10'd700) begin errors++; $display("FAIL x700_x: got %0d expected 700", ox); end
    read_cell(65, 500, ent, ox, oy);
    checks++; if (ent !== 2'd3) begin errors++; $display("FAIL y500: got %0d expected 3", ent); end
    checks++; if (oy !== 10'd500) begin errors++; $display("FAIL y500_y: got %0d expected 500", oy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ent;
    logic [9:0] ox, oy;
    iWr_en = 1'b1; iWr_col = 5'd10; iWr_row = 5'd10; iWr_ent = 2'd1;
    tick(1);
    checks++; if (oWr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack0: got %0b expected 1", oWr_ack); end
    iWr_col = 5'd11; iWr_ent = 2'd2;
    tick(1);
    iWr_en = 1'b0;
    checks++; if (oWr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %0b expected 1", oWr_ack); end
    read_cell(205, 205, ent, ox, oy);
    checks++; if (ent !== 2'd1) begin errors++; $display("FAIL b2b_cell0: got %0d expected 1", ent); end
    read_cell(225, 205, ent, ox, oy);
    checks++; if (ent !== 2'd2) begin errors++; $display("FAIL b2b_cell1: got %0d expected 2", ent); end
  endtask

  task automatic test_same_cycle();
    logic ack;
    do_write(0, 0, 2'd0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rbw_setup_ack: got %0b expected 1", ack); end
    iVGA_X = 10'd0;
    iVGA_Y = 10'd0;
    tick(1);
    // The RAM read of cell (0,0) and the write of TAIL share this edge.
    iWr_en = 1'b1; iWr_col = 5'd0; iWr_row = 5'd0; iWr_ent = 2'd2;
    tick(1);
    iWr_en = 1'b0;
    checks++; if (oEnt !== 2'd0) begin errors++; $display("FAIL rbw_old: got %0d expected 0", oEnt); end
    checks++; if (oWr_ack !== 1'b1) begin errors++; $display("FAIL rbw_ack: got %0b expected 1", oWr_ack); end
    tick(1);
    checks++; if (oEnt !== 2'd2) begin errors++; $display("FAIL rbw_new: got %0d expected 2", oEnt); end
  endtask

  task automatic test_oob_write();
    logic ack;
    logic [1:0] ent;
    logic [9:0] ox, oy;
    do_write(0, 24, 2'd1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL oob_row24_ack: got %0b expected 0", ack); end
    do_write(0, 31, 2'd1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL oob_row31_ack: got %0b expected 0", ack); end
    read_cell(0, 0, ent, ox, oy);
    checks++; if (ent !== 2'd2) begin errors++; $display("FAIL oob_unchanged: got %0d expected 2", ent); end
  endtask

  task automatic test_clear();
    logic ack;
    logic [1:0] ent;
    logic [9:0] ox, oy;
    int cnt;
    int cols[4] = '{5, 6, 7, 31};
    int rows[4] = '{5, 6, 7, 23};
    do_write(5, 5, 2'd1, ack);
    read_cell(105, 105, ent, ox, oy);
    checks++; if (ent !== 2'd1) begin errors++; $display("FAIL clr_pre_cell: got %0d expected 1", ent); end
    // Write and clear in the same IDLE cycle: write lands, sweep starts.
    iWr_en = 1'b1; iWr_col = 5'd6; iWr_row = 5'd6; iWr_ent = 2'd2; iClear = 1'b1;
    tick(1);
    iWr_en = 1'b0; iClear = 1'b0;
    cnt = 0;
    checks++; if (oWr_ack !== 1'b1) begin errors++; $display("FAIL clr_same_ack: got %0b expected 1", oWr_ack); end
    checks++; if (oClear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %0b expected 1", oClear_busy); end
    do_write(7, 7, 2'd1, ack);
    cnt++;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL clr_wr_dropped: got %0b expected 0", ack); end
    read_cell(639, 479, ent, ox, oy);
    cnt += 2;
    checks++; if (ent !== 2'd3) begin errors++; $display("FAIL clr_masked: got %0d expected 3", ent); end
    tick(97);
    cnt += 97;
    iClear = 1'b1;
    tick(1);
    iClear = 1'b0;
    cnt++;
    while (oClear_busy === 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    checks++; if (cnt != 768) begin errors++; $display("FAIL clr_len: got %0d cycles expected 768", cnt); end
    for (int i = 0; i < 4; i++) begin
      read_cell(cols[i] * 20 + 3, rows[i] * 20 + 3, ent, ox, oy);
      checks++; if (ent !== 2'd3) begin errors++; $display("FAIL clr_cell_%0d_%0d: got %0d expected 3", cols[i], rows[i], ent); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    logic ack;
    logic [1:0] ent;
    logic [9:0] ox, oy;
    iVGA_X = 10'd65;
    iVGA_Y = 10'd45;
    iClear = 1'b1;
    tick(1);
    iClear = 1'b0;
    tick(300);
    reset_n = 1'b0;
    #1;
    checks++; if (oEnt !== 2'd3) begin errors++; $display("FAIL mid_rst_ent: got %0d expected 3", oEnt); end
    checks++; if (oVGA_X !== 10'd0) begin errors++; $display("FAIL mid_rst_x: got %0d expected 0", oVGA_X); end
    checks++; if (oVGA_Y !== 10'd0) begin errors++; $display("FAIL mid_rst_y: got %0d expected 0", oVGA_Y); end
    checks++; if (oWr_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: got %0b expected 0", oWr_ack); end
    checks++; if (oClear_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %0b expected 1", oClear_busy); end
    tick(1);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (oClear_busy === 1'b1 && cnt < 2000);
    checks++; if (cnt != 768) begin errors++; $display("FAIL mid_rst_sweep_len: got %0d cycles expected 768", cnt); end
    do_write(3, 2, 2'd1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL post_rst_ack: got %0b expected 1", ack); end
    read_cell(65, 45, ent, ox, oy);
    checks++; if (ent !== 2'd1) begin errors++; $display("FAIL post_rst_cell: got %0d expected 1", ent); end
  endtask

  // Test sequence and final report
  initial begin
    reset_n = 1'b0;
    iVGA_X  = '0;
    iVGA_Y  = '0;
    iWr_en  = 1'b0;
    iWr_col = '0;
    iWr_row = '0;
    iWr_ent = '0;
    iClear  = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_grid();
    test_back_to_back();
    test_same_cycle();
    test_oob_write();
    test_clear();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
